// File: rtl/rvfpm_offload_ctrl_if.sv
// Core/FPU-side signal bundle for rvfpm_offload_ctrl. master = the controller, slave = core + in_rvfpm.
// err_timeout exists only when RVFPM_OFFLOAD_TIMEOUT_EN is defined.
interface rvfpm_offload_ctrl_if #(
   parameter int XLEN            = 32,
   parameter int FLEN            = 32,
   parameter int X_ID_WIDTH      = 4,
   parameter int MAX_OUTSTANDING = 8
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   logic                  core_valid;
   logic                  core_ready;
   logic [31:0]           core_instr;
   logic [XLEN-1:0]       core_rs1_data;
   logic [FLEN-1:0]       core_mem_rdata;
   logic                  fpu_enable;
   logic [31:0]           fpu_instruction;
   logic [X_ID_WIDTH-1:0] fpu_id;
   logic [XLEN-1:0]       fpu_data_fromXreg;
   logic [FLEN-1:0]       fpu_data_fromMem;
   logic [X_ID_WIDTH-1:0] fpu_id_out;
   logic [XLEN-1:0]       fpu_data_toXreg;
   logic                  fpu_toXreg_valid;
   logic [FLEN-1:0]       fpu_data_toMem;
   logic                  fpu_toMem_valid;
   logic                  wb_valid;
   logic [4:0]            wb_rd;
   logic [XLEN-1:0]       wb_data;
   logic                  st_valid;
   logic [X_ID_WIDTH-1:0] st_id;
   logic [FLEN-1:0]       st_data;
   logic [OW-1:0]         outstanding;
   logic                  err_spurious;

`ifdef RVFPM_OFFLOAD_TIMEOUT_EN
   logic                  err_timeout;

   modport master (
      input  core_valid, core_instr, core_rs1_data, core_mem_rdata,
      input  fpu_id_out, fpu_data_toXreg, fpu_toXreg_valid, fpu_data_toMem, fpu_toMem_valid,
      output core_ready, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg, fpu_data_fromMem,
      output wb_valid, wb_rd, wb_data, st_valid, st_id, st_data, outstanding, err_spurious,
      output err_timeout
   );
   modport slave (
      output core_valid, core_instr, core_rs1_data, core_mem_rdata,
      output fpu_id_out, fpu_data_toXreg, fpu_toXreg_valid, fpu_data_toMem, fpu_toMem_valid,
      input  core_ready, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg, fpu_data_fromMem,
      input  wb_valid, wb_rd, wb_data, st_valid, st_id, st_data, outstanding, err_spurious,
      input  err_timeout
   );
`else
   modport master (
      input  core_valid, core_instr, core_rs1_data, core_mem_rdata,
      input  fpu_id_out, fpu_data_toXreg, fpu_toXreg_valid, fpu_data_toMem, fpu_toMem_valid,
      output core_ready, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg, fpu_data_fromMem,
      output wb_valid, wb_rd, wb_data, st_valid, st_id, st_data, outstanding, err_spurious
   );
   modport slave (
      output core_valid, core_instr, core_rs1_data, core_mem_rdata,
      output fpu_id_out, fpu_data_toXreg, fpu_toXreg_valid, fpu_data_toMem, fpu_toMem_valid,
      input  core_ready, fpu_enable, fpu_instruction, fpu_id, fpu_data_fromXreg, fpu_data_fromMem,
      input  wb_valid, wb_rd, wb_data, st_valid, st_id, st_data, outstanding, err_spurious
   );
`endif
endinterface

// File: rtl/rvfpm_offload_ctrl.sv
// Core-side offload controller for in_rvfpm: issues FP instructions with ids, tracks result-producing
// ones in a scoreboard and routes results to writeback/store. Optional per-id timeout: RVFPM_OFFLOAD_TIMEOUT_EN.
module rvfpm_offload_ctrl #(
   parameter int         XLEN            = 32,
   parameter int         FLEN            = 32,
   parameter int         X_ID_WIDTH      = 4,
   parameter int         MAX_OUTSTANDING = 8,
   parameter logic [6:0] LOAD_OPCODE     = 7'b0000011,
   parameter logic [6:0] STORE_OPCODE    = 7'b0100011,
   parameter int         TIMEOUT_CYCLES  = 64
) (
   input logic                  ck,
   input logic                  rst,
   rvfpm_offload_ctrl_if.master bus
);
   localparam int                    NUM_IDS = 2 ** X_ID_WIDTH;
   localparam int                    OW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0]         MAX_CNT = OW'(MAX_OUTSTANDING);
   localparam logic [OW-1:0]         CNT_ONE = OW'(1);
   localparam logic [X_ID_WIDTH-1:0] ID_ONE  = X_ID_WIDTH'(1);
   localparam logic [6:0]            OP_FP   = 7'b1010011;

   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_IDS || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("rvfpm_offload_ctrl: MAX_OUTSTANDING or TIMEOUT_CYCLES out of range");
   end

   typedef enum logic [1:0] {KIND_NONE, KIND_XREG, KIND_MEM} kind_e;

   logic                  rst_q;
   logic                  fpu_enable_q;
   logic [31:0]           fpu_instruction_q;
   logic [X_ID_WIDTH-1:0] fpu_id_q;
   logic [XLEN-1:0]       fpu_xdata_q;
   logic [FLEN-1:0]       fpu_mdata_q;
   logic                  wb_valid_q;
   logic [4:0]            wb_rd_q;
   logic [XLEN-1:0]       wb_data_q;
   logic                  st_valid_q;
   logic [X_ID_WIDTH-1:0] st_id_q;
   logic [FLEN-1:0]       st_data_q;
   logic [OW-1:0]         outstanding_q;
   logic [OW-1:0]         outstanding_d;
   logic [OW-1:0]         n_tmo;
   logic                  err_spurious_q;
   logic [X_ID_WIDTH-1:0] next_id;

   logic [NUM_IDS-1:0]    sb_valid;
   logic [NUM_IDS-1:0]    sb_is_mem;
   logic [4:0]            sb_rd [NUM_IDS];

   kind_e                 kind;
   logic                  handshake;
   logic                  issue_trk;
   logic                  hit_valid;
   logic                  xreg_hit;
   logic                  mem_hit;
   logic                  retire;
   logic                  spurious;

   always_comb begin
      kind = KIND_NONE;
      if (bus.core_instr[6:0] == STORE_OPCODE) begin
         kind = KIND_MEM;
      end else if (bus.core_instr[6:0] == OP_FP &&
                   (bus.core_instr[31:27] == 5'b11100 || bus.core_instr[31:27] == 5'b11000 ||
                    bus.core_instr[31:27] == 5'b10100)) begin
         kind = KIND_XREG;
      end else if (bus.core_instr[6:0] == LOAD_OPCODE) begin
         kind = KIND_NONE;
      end
   end

   // valid/ready: an instruction transfers on a rising edge of ck where core_valid && core_ready;
   // core_ready depends only on state and the presented core_instr, never on core_valid.
   assign bus.core_ready = !rst && !rst_q &&
                           (kind == KIND_NONE || (outstanding_q < MAX_CNT && !sb_valid[next_id]));
   assign handshake = bus.core_valid && bus.core_ready;
   assign issue_trk = handshake && kind != KIND_NONE;

   // Both result strobes share fpu_id_out; at most one of them can match the entry's kind.
   assign hit_valid = sb_valid[bus.fpu_id_out];
   assign xreg_hit  = bus.fpu_toXreg_valid && hit_valid && !sb_is_mem[bus.fpu_id_out];
   assign mem_hit   = bus.fpu_toMem_valid && hit_valid && sb_is_mem[bus.fpu_id_out];
   assign retire    = xreg_hit || mem_hit;
   assign spurious  = (bus.fpu_toXreg_valid && !xreg_hit) || (bus.fpu_toMem_valid && !mem_hit);

`ifdef RVFPM_OFFLOAD_TIMEOUT_EN
   localparam int               AGE_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AGE_W-1:0] TMO_CNT = AGE_W'(TIMEOUT_CYCLES);
   localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
   logic [AGE_W-1:0]            age [NUM_IDS];
   logic [NUM_IDS-1:0]          tmo;
   logic                        err_timeout_q;
   assign bus.err_timeout = err_timeout_q;
`endif

   always_comb begin
      n_tmo = '0;
`ifdef RVFPM_OFFLOAD_TIMEOUT_EN
      tmo = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         // An entry retiring this cycle is not also counted as timed out.
         tmo[i] = sb_valid[i] && age[i] == TMO_CNT &&
                  !(retire && bus.fpu_id_out == X_ID_WIDTH'(i));
         if (tmo[i]) n_tmo = n_tmo + CNT_ONE;
      end
`endif
      outstanding_d = outstanding_q + OW'(issue_trk) - OW'(retire) - n_tmo;
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         rst_q             <= 1'b1;
         fpu_enable_q      <= 1'b0;
         fpu_instruction_q <= '0;
         fpu_id_q          <= '0;
         fpu_xdata_q       <= '0;
         fpu_mdata_q       <= '0;
         wb_valid_q        <= 1'b0;
         wb_rd_q           <= '0;
         wb_data_q         <= '0;
         st_valid_q        <= 1'b0;
         st_id_q           <= '0;
         st_data_q         <= '0;
         outstanding_q     <= '0;
         err_spurious_q    <= 1'b0;
         next_id           <= '0;
         sb_valid          <= '0;
         sb_is_mem         <= '0;
         for (int i = 0; i < NUM_IDS; i++) sb_rd[i] <= '0;
`ifdef RVFPM_OFFLOAD_TIMEOUT_EN
         for (int i = 0; i < NUM_IDS; i++) age[i] <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         rst_q             <= 1'b0;
         fpu_enable_q      <= 1'b1;
         fpu_instruction_q <= handshake ? bus.core_instr     : '0;
         fpu_id_q          <= handshake ? next_id            : '0;
         fpu_xdata_q       <= handshake ? bus.core_rs1_data  : '0;
         fpu_mdata_q       <= handshake ? bus.core_mem_rdata : '0;
         if (handshake) next_id <= next_id + ID_ONE;
         if (issue_trk) begin
            sb_valid[next_id]  <= 1'b1;
            sb_is_mem[next_id] <= (kind == KIND_MEM);
            sb_rd[next_id]     <= bus.core_instr[11:7];
         end
         if (retire) sb_valid[bus.fpu_id_out] <= 1'b0;
         wb_valid_q    <= xreg_hit;
         wb_rd_q       <= xreg_hit ? sb_rd[bus.fpu_id_out] : '0;
         wb_data_q     <= xreg_hit ? bus.fpu_data_toXreg   : '0;
         st_valid_q    <= mem_hit;
         st_id_q       <= mem_hit ? bus.fpu_id_out         : '0;
         st_data_q     <= mem_hit ? bus.fpu_data_toMem     : '0;
         if (spurious) err_spurious_q <= 1'b1;
         outstanding_q <= outstanding_d;
`ifdef RVFPM_OFFLOAD_TIMEOUT_EN
         for (int i = 0; i < NUM_IDS; i++) begin
            if (tmo[i]) sb_valid[i] <= 1'b0;
            if (issue_trk && next_id == X_ID_WIDTH'(i)) age[i] <= '0;
            else if (sb_valid[i]) age[i] <= age[i] + AGE_ONE;
         end
         if (|tmo) err_timeout_q <= 1'b1;
`endif
      end
   end

   assign bus.fpu_enable        = fpu_enable_q;
   assign bus.fpu_instruction   = fpu_instruction_q;
   assign bus.fpu_id            = fpu_id_q;
   assign bus.fpu_data_fromXreg = fpu_xdata_q;
   assign bus.fpu_data_fromMem  = fpu_mdata_q;
   assign bus.wb_valid          = wb_valid_q;
   assign bus.wb_rd             = wb_rd_q;
   assign bus.wb_data           = wb_data_q;
   assign bus.st_valid          = st_valid_q;
   assign bus.st_id             = st_id_q;
   assign bus.st_data           = st_data_q;
   assign bus.outstanding       = outstanding_q;
   assign bus.err_spurious      = err_spurious_q;
endmodule

// File: tb/tb_rvfpm_offload_ctrl.sv
// Bench for rvfpm_offload_ctrl: directed issue/result traffic, expected responses queued at
// stimulus time and popped by negedge monitors on the fpu issue bus, writeback and store ports.
module tb_rvfpm_offload_ctrl;
   localparam logic [31:0] I_LOAD  = 32'h0000_2083;
   localparam logic [31:0] I_STORE = 32'h0001_A1A3;
   localparam logic [31:0] I_FMV   = 32'hE000_8553;

   logic ck = 1'b0;
   logic rst = 1'b1;
   logic mon_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] exp_id = '0;

   logic [99:0] exp_iss [$];
   logic [36:0] exp_wb  [$];
   logic [35:0] exp_st  [$];

   rvfpm_offload_ctrl_if #(.XLEN(32), .FLEN(32), .X_ID_WIDTH(4), .MAX_OUTSTANDING(8)) bus ();

   rvfpm_offload_ctrl #(.XLEN(32), .FLEN(32), .X_ID_WIDTH(4), .MAX_OUTSTANDING(8)) dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus)
   );

   // clock / watchdog
   always #5 ck = ~ck;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // drivers: called just after a rising edge, return just after a rising edge
   task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] mem);
      int waited = 0;
      bus.core_valid     = 1'b1;
      bus.core_instr     = instr;
      bus.core_rs1_data  = rs1;
      bus.core_mem_rdata = mem;
      @(negedge ck);
      while (!bus.core_ready && waited < 50) begin
         waited++;
         @(negedge ck);
      end
      checks++;
      if (!bus.core_ready) begin
         errors++;
         $display("FAIL issue_ready: core_ready=0 after %0d cycles for instr 0x%08h", waited, instr);
      end else begin
         exp_iss.push_back({instr, exp_id, rs1, mem});
         exp_id++;
      end
      @(posedge ck);
      #1;
      bus.core_valid = 1'b0;
   endtask

   task automatic send_res(input logic to_x, input logic to_m, input logic [3:0] id,
                           input logic [31:0] data);
      bus.fpu_toXreg_valid = to_x;
      bus.fpu_toMem_valid  = to_m;
      bus.fpu_id_out       = id;
      bus.fpu_data_toXreg  = data;
      bus.fpu_data_toMem   = data;
      @(posedge ck);
      #1;
      bus.fpu_toXreg_valid = 1'b0;
      bus.fpu_toMem_valid  = 1'b0;
   endtask

   // scoreboard monitors
   always @(negedge ck) begin
      if (mon_en) begin
         logic [99:0] got_i;
         got_i = {bus.fpu_instruction, bus.fpu_id, bus.fpu_data_fromXreg, bus.fpu_data_fromMem};
         checks++;
         if (bus.fpu_instruction != 32'h0) begin
            if (exp_iss.size() == 0) begin
               errors++;
               $display("FAIL fpu_issue: unexpected issue %h", got_i);
            end else begin
               logic [99:0] e;
               e = exp_iss.pop_front();
               if (got_i !== e) begin
                  errors++;
                  $display("FAIL fpu_issue: got %h expected %h", got_i, e);
               end
            end
         end else if (bus.fpu_data_fromXreg != 32'h0 || bus.fpu_data_fromMem != 32'h0) begin
            errors++;
            $display("FAIL fpu_idle: data buses %h/%h expected 0", bus.fpu_data_fromXreg,
                     bus.fpu_data_fromMem);
         end
         if (bus.wb_valid) begin
            checks++;
            if (exp_wb.size() == 0) begin
               errors++;
               $display("FAIL wb: unexpected pulse rd=%0d data=0x%08h", bus.wb_rd, bus.wb_data);
            end else begin
               logic [36:0] e;
               e = exp_wb.pop_front();
               if ({bus.wb_rd, bus.wb_data} !== e) begin
                  errors++;
                  $display("FAIL wb: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                           bus.wb_rd, bus.wb_data, e[36:32], e[31:0]);
               end
            end
         end
         if (bus.st_valid) begin
            checks++;
            if (exp_st.size() == 0) begin
               errors++;
               $display("FAIL st: unexpected pulse id=%0d data=0x%08h", bus.st_id, bus.st_data);
            end else begin
               logic [35:0] e;
               e = exp_st.pop_front();
               if ({bus.st_id, bus.st_data} !== e) begin
                  errors++;
                  $display("FAIL st: got id=%0d data=0x%08h expected id=%0d data=0x%08h",
                           bus.st_id, bus.st_data, e[35:32], e[31:0]);
               end
            end
         end
      end
   end

   initial begin
      bus.core_valid       = 1'b0;
      bus.core_instr       = '0;
      bus.core_rs1_data    = '0;
      bus.core_mem_rdata   = '0;
      bus.fpu_id_out       = '0;
      bus.fpu_data_toXreg  = '0;
      bus.fpu_toXreg_valid = 1'b0;
      bus.fpu_data_toMem   = '0;
      bus.fpu_toMem_valid  = 1'b0;

      // reset
      repeat (3) @(posedge ck);
      #1;
      chk("rst_core_ready", 32'(bus.core_ready), 32'd0);
      chk("rst_fpu_enable", 32'(bus.fpu_enable), 32'd0);
      chk("rst_fpu_instr", bus.fpu_instruction, 32'd0);
      chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
      chk("rst_err", 32'(bus.err_spurious), 32'd0);
      chk("rst_pulses", {30'd0, bus.wb_valid, bus.st_valid}, 32'd0);
      rst = 1'b0;
      @(posedge ck);
      #1;
      chk("rel_core_ready", 32'(bus.core_ready), 32'd1);
      chk("rel_fpu_enable", 32'(bus.fpu_enable), 32'd1);
      mon_en = 1'b1;

      // load: fire-and-forget, id 0
      issue(I_LOAD, 32'h0, 32'h3F80_0000);
      @(posedge ck);
      #1;
      chk("load_idle_instr", bus.fpu_instruction, 32'd0);
      chk("load_outstanding", 32'(bus.outstanding), 32'd0);

      // store round trip, id 1
      issue(I_STORE, 32'h0000_1000, 32'h0);
      chk("store_outstanding_1", 32'(bus.outstanding), 32'd1);
      exp_st.push_back({4'd1, 32'h4130_28F6});
      send_res(1'b0, 1'b1, 4'd1, 32'h4130_28F6);
      chk("store_outstanding_0", 32'(bus.outstanding), 32'd0);
      @(posedge ck);
      #1;
      chk("store_pulse_once", 32'(bus.st_valid), 32'd0);

      // fmv.x.w rd=10, id 2
      issue(I_FMV, 32'h1234_5678, 32'h0);
      exp_wb.push_back({5'd10, 32'hDEAD_BEEF});
      send_res(1'b1, 1'b0, 4'd2, 32'hDEAD_BEEF);
      chk("fmv_outstanding", 32'(bus.outstanding), 32'd0);
      @(posedge ck);
      #1;
      chk("wb_pulse_once", 32'(bus.wb_valid), 32'd0);

      // spurious result for id 7
      send_res(1'b1, 1'b0, 4'd7, 32'h5555_5555);
      chk("spur_err", 32'(bus.err_spurious), 32'd1);
      chk("spur_outstanding", 32'(bus.outstanding), 32'd0);
      repeat (2) @(posedge ck);
      #1;
      chk("spur_sticky", 32'(bus.err_spurious), 32'd1);

      // full: 8 stores at ids 3..10
      for (int i = 0; i < 8; i++) issue(I_STORE, 32'h100 + i, 32'h0);
      chk("full_outstanding", 32'(bus.outstanding), 32'd8);
      chk("full_ready_store", 32'(bus.core_ready), 32'd0);
      bus.core_instr = I_LOAD;
      #1;
      chk("full_ready_load", 32'(bus.core_ready), 32'd1);
      bus.core_instr = I_STORE;
      #1;
      exp_st.push_back({4'd3, 32'h1111_1111});
      send_res(1'b0, 1'b1, 4'd3, 32'h1111_1111);
      chk("unfull_ready", 32'(bus.core_ready), 32'd1);
      chk("unfull_outstanding", 32'(bus.outstanding), 32'd7);
      issue(I_STORE, 32'h200, 32'h0);
      for (int i = 5; i <= 11; i++) begin
         exp_st.push_back({4'(i), 32'hA000_0000 + i});
         send_res(1'b0, 1'b1, 4'(i), 32'hA000_0000 + i);
      end
      chk("drain_outstanding", 32'(bus.outstanding), 32'd1);

      // wrap: 8 loads move next_id 12 -> 4, where id 4 is still pending
      for (int i = 0; i < 8; i++) issue(I_LOAD, 32'h0, 32'hB000_0000 + i);
      bus.core_instr = I_STORE;
      #1;
      chk("wrap_blocked", 32'(bus.core_ready), 32'd0);
      exp_st.push_back({4'd4, 32'h4444_4444});
      send_res(1'b0, 1'b1, 4'd4, 32'h4444_4444);
      chk("wrap_unblocked", 32'(bus.core_ready), 32'd1);
      issue(I_STORE, 32'h300, 32'h0);
      chk("wrap_outstanding", 32'(bus.outstanding), 32'd1);

      // mid-operation reset with a result arriving during rst
      rst = 1'b1;
      bus.fpu_toXreg_valid = 1'b1;
      bus.fpu_id_out       = 4'd4;
      @(posedge ck);
      #1;
      rst = 1'b0;
      bus.fpu_toXreg_valid = 1'b0;
      exp_id = '0;
      chk("mid_rst_outstanding", 32'(bus.outstanding), 32'd0);
      chk("mid_rst_err", 32'(bus.err_spurious), 32'd0);
      chk("mid_rst_enable", 32'(bus.fpu_enable), 32'd0);
      chk("mid_rst_ready", 32'(bus.core_ready), 32'd0);

      // kind mismatch: toXreg for a MEM entry at id 0
      issue(I_STORE, 32'h400, 32'h0);
      send_res(1'b1, 1'b0, 4'd0, 32'hCAFE_F00D);
      chk("mismatch_err", 32'(bus.err_spurious), 32'd1);
      chk("mismatch_outstanding", 32'(bus.outstanding), 32'd1);

      // simultaneous issue (id 1) and retire (id 0)
      bus.core_valid       = 1'b1;
      bus.core_instr       = I_STORE;
      bus.core_rs1_data    = 32'h500;
      bus.core_mem_rdata   = 32'h0;
      bus.fpu_toMem_valid  = 1'b1;
      bus.fpu_id_out       = 4'd0;
      bus.fpu_data_toMem   = 32'h0BAD_F00D;
      @(negedge ck);
      chk("simul_ready", 32'(bus.core_ready), 32'd1);
      exp_iss.push_back({I_STORE, exp_id, 32'h500, 32'h0});
      exp_id++;
      exp_st.push_back({4'd0, 32'h0BAD_F00D});
      @(posedge ck);
      #1;
      bus.core_valid      = 1'b0;
      bus.fpu_toMem_valid = 1'b0;
      chk("simul_outstanding", 32'(bus.outstanding), 32'd1);
      exp_st.push_back({4'd1, 32'h7777_7777});
      send_res(1'b0, 1'b1, 4'd1, 32'h7777_7777);
      chk("final_outstanding", 32'(bus.outstanding), 32'd0);

      repeat (3) @(posedge ck);
      #1;
      chk("left_iss", 32'(exp_iss.size()), 32'd0);
      chk("left_wb", 32'(exp_wb.size()), 32'd0);
      chk("left_st", 32'(exp_st.size()), 32'd0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
